alu_32_bit: RTL and testbench

Registered 32-bit integer ALU performing AND, OR, ADD, SUB and set-on-less-than on two 32-bit operands, selected by a 3-bit opcode. It is the execute-stage arithmetic unit of the datapath: operands and opcode are driven combinationally from the decode/operand stage and the result is captured into output registers on each rising clock edge. The datapath is a ripple chain of 1-bit ALU slices.

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_1_bit.sv | 22 ++
 rtl/alu_32_bit.sv | 55 +++++
 tb/tb_alu_32_bit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and opcode type shared by the ALU slice and top
package alu_pkg;
    typedef logic [2:0] alu_op_t;
    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_SLT = 3'b111;
endpackage

// File: rtl/alu_1_bit.sv
// alu_1_bit: one ALU slice -- AND, OR, full adder with optional b inversion, less passthrough
module alu_1_bit (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       bInvert,
    input  logic       less,
    input  logic [1:0] sel,
    output logic       result,
    output logic       sum,
    output logic       cout
);
    logic bx;
    assign bx   = b ^ bInvert;
    assign sum  = a ^ bx ^ cin;
    assign cout = (a & bx) | (a & cin) | (bx & cin);
    always_comb begin
        result = sel == 2'b00 ? a & b :
                 sel == 2'b01 ? a | b :
                 sel == 2'b10 ? sum : less;
    end
endmodule

// File: rtl/alu_32_bit.sv
// alu_32_bit: registered 32-bit ALU (AND/OR/ADD/SUB/SLT) built from a ripple chain of 1-bit slices
module alu_32_bit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carryIn,
    input  logic [2:0]  AluOp,
    output logic [31:0] outputAlu,
    output logic        carryOut
);
    alu_op_t     op;
    logic        bInvert, sumOp, arith, reserved, cin0, ovf, lt;
    logic [31:0] resV, sumV, nextResult;
    logic        nextCarry;
    assign op       = AluOp;
    assign bInvert  = op == ALU_SUB || op == ALU_SLT;
    assign sumOp    = op == ALU_ADD || op == ALU_SUB;
    assign arith    = sumOp || op == ALU_SLT;
    assign reserved = !(arith || op == ALU_AND || op == ALU_OR);
    assign cin0     = bInvert ? 1'b1 : carryIn;
    // Each slice owns its carry so the ripple is a chain of distinct nets.
    genvar i;
    for (i = 0; i < 32; i++) begin : g
        logic ci, co;
        if (i == 0) begin : c
            assign ci = cin0;
        end else begin : c
            assign ci = g[i-1].co;
        end
        alu_1_bit u (
            .a(a[i]), .b(b[i]), .cin(ci), .bInvert(bInvert),
            .less(i == 0 ? lt : 1'b0), .sel(op[1:0]),
            .result(resV[i]), .sum(sumV[i]), .cout(co)
        );
    end
    // Sign of a-b corrected by overflow gives a signed compare valid across wraparound.
    assign ovf = g[31].ci ^ g[31].co;
    assign lt  = sumV[31] ^ ovf;
    always_comb begin
        nextResult = reserved ? 32'd0 : sumOp ? sumV : resV;
        nextCarry  = arith ? g[31].co : 1'b0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outputAlu <= 32'd0;
            carryOut  <= 1'b0;
        end else begin
            outputAlu <= nextResult;
            carryOut  <= nextCarry;
        end
    end
endmodule

// File: tb/tb_alu_32_bit.sv
// tb_alu_32_bit: table-driven checks of the registered ALU plus async reset and latency sequences
module tb_alu_32_bit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        carryIn = 1'b0;
    logic [2:0]  AluOp = 3'b000;
    logic [31:0] outputAlu;
    logic        carryOut;
    int checks = 0;
    int errors = 0;

    alu_32_bit dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .carryIn(carryIn),
        .AluOp(AluOp), .outputAlu(outputAlu), .carryOut(carryOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [2:0]  op;
        logic [31:0] expR;
        logic        expC;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic vc, input logic [2:0] vo);
        @(negedge clk);
        a = va; b = vb; carryIn = vc; AluOp = vo;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hED5AB56A, 32'h5EFDFBF7, 1'b0, 3'b000, 32'h4C58B162, 1'b0};
        vecs[1]  = '{32'hED5AB56A, 32'h5EFDFBF7, 1'b1, 3'b000, 32'h4C58B162, 1'b0};
        vecs[2]  = '{32'hAAAAAAAA, 32'h63636363, 1'b0, 3'b001, 32'hEBEBEBEB, 1'b0};
        vecs[3]  = '{32'h2A2A2A2A, 32'h2A2A2A2A, 1'b0, 3'b010, 32'h54545454, 1'b0};
        vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b010, 32'h00000000, 1'b1};
        vecs[5]  = '{32'h00000000, 32'h00000000, 1'b1, 3'b010, 32'h00000001, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b010, 32'h00000000, 1'b1};
        vecs[7]  = '{32'h7A7A7A7A, 32'h2A2A2A2A, 1'b0, 3'b110, 32'h50505050, 1'b1};
        vecs[8]  = '{32'h7A7A7A7A, 32'h2A2A2A2A, 1'b1, 3'b110, 32'h50505050, 1'b1};
        vecs[9]  = '{32'h00000000, 32'h00000001, 1'b0, 3'b110, 32'hFFFFFFFF, 1'b0};
        vecs[10] = '{32'hA0000000, 32'hB0000000, 1'b0, 3'b111, 32'h00000001, 1'b0};
        vecs[11] = '{32'h80000000, 32'h00000001, 1'b0, 3'b111, 32'h00000001, 1'b1};
        vecs[12] = '{32'h00000005, 32'hFFFFFFFF, 1'b0, 3'b111, 32'h00000000, 1'b0};
        vecs[13] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 3'b111, 32'h00000000, 1'b0};
        vecs[14] = '{32'h12345678, 32'h12345678, 1'b0, 3'b111, 32'h00000000, 1'b1};
        vecs[15] = '{32'h00000000, 32'h00000001, 1'b1, 3'b011, 32'h00000000, 1'b0};
        vecs[16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3'b100, 32'h00000000, 1'b0};
        vecs[17] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3'b101, 32'h00000000, 1'b0};

        // Reset held from time 0: outputs must be cleared before any clock edge.
        #1;
        check("reset_init_result", outputAlu, 32'd0);
        check("reset_init_carry", {31'd0, carryOut}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op);
            check($sformatf("vec%0d_result", i), outputAlu, vecs[i].expR);
            check($sformatf("vec%0d_carry", i), {31'd0, carryOut}, {31'd0, vecs[i].expC});
        end

        // One-cycle latency: new inputs must not show until the next edge.
        apply(32'h2A2A2A2A, 32'h2A2A2A2A, 1'b0, 3'b010);
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'h00000001; AluOp = 3'b010;
        #1;
        check("latency_hold_result", outputAlu, 32'h54545454);
        check("latency_hold_carry", {31'd0, carryOut}, 32'd0);
        @(posedge clk);
        #1;
        check("latency_load_result", outputAlu, 32'h00000000);
        check("latency_load_carry", {31'd0, carryOut}, 32'd1);

        // Async reset mid-cycle while outputs are nonzero.
        @(negedge clk);
        a = 32'hAAAAAAAA; b = 32'h63636363; AluOp = 3'b001;
        @(posedge clk);
        #1;
        check("pre_reset_result", outputAlu, 32'hEBEBEBEB);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_result", outputAlu, 32'd0);
        check("async_reset_carry", {31'd0, carryOut}, 32'd0);
        a = 32'hFFFFFFFF; b = 32'h00000001; AluOp = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_result", outputAlu, 32'd0);
        check("reset_hold_carry", {31'd0, carryOut}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        AluOp = 3'b101;
        @(posedge clk);
        #1;
        check("post_reset_reserved_result", outputAlu, 32'd0);
        check("post_reset_reserved_carry", {31'd0, carryOut}, 32'd0);
        apply(32'h2A2A2A2A, 32'h2A2A2A2A, 1'b0, 3'b010);
        check("post_reset_add_result", outputAlu, 32'h54545454);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
